// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed 8-digit seven-segment scanner with per-slot dead time and frame snapshot.
// Optional: define LEADING_ZERO_BLANK_EN to blank a "0" shown on tens-digit (even) slots.
module seven_seg_scan_mux #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLANK_CYC = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic [6:0] SN1D1,
  input  logic [6:0] SN1D2,
  input  logic [6:0] SN2D1,
  input  logic [6:0] SN2D2,
  input  logic [6:0] WE1D1,
  input  logic [6:0] WE1D2,
  input  logic [6:0] WE2D1,
  input  logic [6:0] WE2D2,
  output logic [6:0] SEG,
  output logic [7:0] AN,
  output logic       FRAME_TICK
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned DIG_W   = 3;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned NUM_DIG = 8;
  localparam logic [SEG_W-1:0] CODE_ZERO = 7'b0111111;

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [DIG_W-1:0]                dig_q, dig_d;
  logic [NUM_DIG-1:0][SEG_W-1:0]   snap_q, snap_d;
  logic [NUM_DIG-1:0][SEG_W-1:0]   codes_c;
  logic [SEG_W-1:0]                seg_d;
  logic [NUM_DIG-1:0]              an_d;
  logic                            tick_d;

  // Slot order: index 0 is SN1D1 ... index 7 is WE2D2.
  assign codes_c = {WE2D2, WE2D1, WE1D2, WE1D1, SN2D2, SN2D1, SN1D2, SN1D1};

  // Next-state and next-output logic; outputs follow the current (dig,cnt) by one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    snap_d  = snap_q;
    seg_d   = '0;
    an_d    = '0;
    tick_d  = 1'b0;
    if (ENABLE) begin
      if (dig_q == '0 && cnt_q == '0) begin
        snap_d = codes_c;
      end
      if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
        cnt_d  = '0;
        dig_d  = dig_q + DIG_W'(1);
        tick_d = (dig_q == DIG_W'(NUM_DIG - 1));
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      case (state_q)
        BLANK: begin
          an_d  = '0;
          seg_d = '0;
        end
        SHOW: begin
          an_d  = NUM_DIG'(1) << dig_q;
          seg_d = snap_q[dig_q];
`ifdef LEADING_ZERO_BLANK_EN
          if (!dig_q[0] && snap_q[dig_q] == CODE_ZERO) begin
            seg_d = '0;
          end
`endif
        end
        default: ;
      endcase
      state_d = (cnt_d < CNT_W'(BLANK_CYC)) ? BLANK : SHOW;
    end else begin
      cnt_d   = '0;
      dig_d   = '0;
      state_d = BLANK;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= BLANK;
      cnt_q      <= '0;
      dig_q      <= '0;
      snap_q     <= '0;
      SEG        <= '0;
      AN         <= '0;
      FRAME_TICK <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dig_q      <= dig_d;
      snap_q     <= snap_d;
      SEG        <= seg_d;
      AN         <= an_d;
      FRAME_TICK <= tick_d;
    end
  end

`ifndef LEADING_ZERO_BLANK_EN
  logic unused_zero_c;
  assign unused_zero_c = ^CODE_ZERO;
`endif

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Randomized check of seven_seg_scan_mux against a position-based frame model.
module tb_seven_seg_scan_mux;

  localparam int unsigned SCAN_DIV  = 10;
  localparam int unsigned BLANK_CYC = 2;
  localparam int unsigned FRAME     = SCAN_DIV * 8;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       ENABLE;
  logic [6:0] codes [8];
  logic [6:0] SEG;
  logic [7:0] AN;
  logic       FRAME_TICK;

  int total = 0;
  int bad   = 0;

  // Model: p counts enabled edges since the last restart.
  int         p = 0;
  logic [6:0] msnap [8];
  logic [7:0] e_an;
  logic [6:0] e_seg;
  logic       e_ft;

  seven_seg_scan_mux #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
    .SN1D1(codes[0]), .SN1D2(codes[1]), .SN2D1(codes[2]), .SN2D2(codes[3]),
    .WE1D1(codes[4]), .WE1D2(codes[5]), .WE2D1(codes[6]), .WE2D2(codes[7]),
    .SEG(SEG), .AN(AN), .FRAME_TICK(FRAME_TICK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s p=%0d observed=%h expected=%h", tag, p, obs, exp);
    end
  endtask

  task automatic model_reset();
    p = 0;
    for (int i = 0; i < 8; i++) msnap[i] = 7'h00;
  endtask

  // Predict the outputs after the next edge from the pre-edge inputs, then compare.
  task automatic cycle();
    int slot, off;
    e_an = 8'h00; e_seg = 7'h00; e_ft = 1'b0;
    if (!RESET) begin
      model_reset();
    end else if (!ENABLE) begin
      p = 0;
    end else begin
      slot = (p / SCAN_DIV) % 8;
      off  = p % SCAN_DIV;
      if (p % FRAME == 0) msnap = codes;
      if (off >= BLANK_CYC) begin
        e_an  = 8'(1 << slot);
        e_seg = msnap[slot];
`ifdef LEADING_ZERO_BLANK_EN
        if (slot % 2 == 0 && e_seg == 7'h3F) e_seg = 7'h00;
`endif
      end
      e_ft = (p % FRAME == FRAME - 1);
      p++;
    end
    @(posedge CLK);
    #1;
    chk("an", AN, e_an);
    chk("seg", 8'(SEG), 8'(e_seg));
    chk("tick", 8'(FRAME_TICK), 8'(e_ft));
    chk("onehot", 8'($countones(AN) <= 1), 8'h01);
  endtask

  task automatic poke_random();
    if ($urandom_range(7) == 0) begin
      if ($urandom_range(3) == 0) codes[$urandom_range(7)] = 7'h3F;
      else codes[$urandom_range(7)] = 7'($urandom);
    end
  endtask

  initial begin
    RESET  = 1'b0;
    ENABLE = 1'b1;
    for (int i = 0; i < 8; i++) codes[i] = 7'($urandom);
    codes[0] = 7'h06;
    model_reset();

    // Held in reset across several edges.
    #32;
    chk("rst_an", AN, 8'h00);
    chk("rst_seg", 8'(SEG), 8'h00);
    chk("rst_tick", 8'(FRAME_TICK), 8'h00);
    RESET = 1'b1;

    // First slot timing from reset release with fixed codes.
    for (int i = 0; i < 14; i++) cycle();

    // Several frames with random code changes; SN2D2 changes during slot 1.
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (p % FRAME == 15) codes[3] = 7'($urandom);
      poke_random();
      cycle();
    end

    // Drop ENABLE during slot 5 for three cycles, change inputs meanwhile.
    for (int i = 0; i < 2 * FRAME && (p % FRAME) != 5 * SCAN_DIV + 4; i++) cycle();
    chk("reach_slot5", 8'((p % FRAME) == 5 * SCAN_DIV + 4), 8'h01);
    ENABLE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      codes[i] = 7'($urandom);
      cycle();
    end
    ENABLE = 1'b1;
    for (int i = 0; i < FRAME + 10; i++) cycle();

    // Tens-digit zero code on slot 4 across a fresh frame.
    codes[4] = 7'h3F;
    codes[0] = 7'h3F;
    codes[5] = 7'h3F;
    for (int i = 0; i < 2 * FRAME; i++) cycle();

    // Asynchronous reset between edges while a digit is shown.
    for (int i = 0; i < 2 * SCAN_DIV && e_an == 8'h00; i++) cycle();
    chk("show_before_rst", 8'(AN != 8'h00), 8'h01);
    #3;
    RESET = 1'b0;
    #1;
    chk("async_an", AN, 8'h00);
    chk("async_seg", 8'(SEG), 8'h00);
    chk("async_tick", 8'(FRAME_TICK), 8'h00);
    cycle();
    #2;
    RESET = 1'b1;
    for (int i = 0; i < FRAME + 5; i++) begin
      poke_random();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
